vram_arbiter: RTL
=================

VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, RAM word address width.
REQ-002 SHALL have parameter DATA_W, default 9, RAM word width (3-bit R/G/B).
REQ-003 SHALL have parameter RD_LAT, default 2, RAM read latency in cycles (1..4).
REQ-004 SHALL have parameter STARVE_MAX, default 8, CPU wait cycles before forced CPU grant (1..255).
REQ-005 SHALL have one clock and asynchronous active-high reset, named as follows: clock  in  1  rising-edge clock for all state.
REQ-006 SHALL have reset  in  1  asynchronous, active-high reset.
REQ-007 SHALL have vga_req  in  1  VGA read request, held until vga_ack.
REQ-008 SHALL have vga_addr  in  ADDR_W  VGA read address, stable while vga_req.
REQ-009 SHALL have vga_ack  out  1  VGA request accepted this cycle.
REQ-010 SHALL have vga_rvalid / vga_rdata  out  1 / DATA_W  VGA read data strobe and data.
REQ-011 SHALL have cpu_req, cpu_we  in  1 each  CPU request and write enable, held until cpu_ack.
REQ-012 SHALL have cpu_addr / cpu_wdata  in  ADDR_W / DATA_W  CPU address and write data.
REQ-013 SHALL have cpu_ack  out  1  CPU request accepted this cycle.
REQ-014 SHALL have cpu_rvalid / cpu_rdata  out  1 / DATA_W  CPU read data strobe and data.
REQ-015 SHALL have ram_address / ram_wren / ram_data  out  ADDR_W / 1 / DATA_W  single RAM port drive, registered.
REQ-016 SHALL have ram_q  in  DATA_W  RAM read data, valid RD_LAT cycles after ram_address.

Function
REQ-017 SHALL grant at most one requester per cycle; vga_ack and cpu_ack are combinational from requests and starvation count, and never both high.
REQ-018 SHALL grant VGA when vga_req is high, unless cpu_req is high and starve_cnt == STARVE_MAX, in which case CPU is granted.
REQ-019 SHALL grant CPU when cpu_req is high and vga_req is low.
REQ-020 SHALL keep starve_cnt (8-bit): +1 each cycle cpu_req && !cpu_ack, saturating at STARVE_MAX; cleared on cpu_ack or when cpu_req is low.
REQ-021 SHALL register the granted address/wren/data onto ram_* on the grant edge; an ack in cycle T drives ram_address in cycle T+1.
REQ-022 SHALL drive ram_wren = 0 and hold ram_address at its last value on idle cycles.
REQ-023 SHALL push an owner tag (NONE/VGA/CPU) into an RD_LAT-deep pipeline each cycle: VGA read gives VGA, CPU read gives CPU, CPU write or idle gives NONE.
REQ-024 SHALL pulse the owner's rvalid and present ram_q on its rdata in cycle T+1+RD_LAT for a read acked in cycle T.
REQ-025 SHALL hold rdata of each port at its last captured value when rvalid is low.
REQ-026 SHALL produce no rvalid for CPU writes; a write is complete at ack.
REQ-027 SHALL sustain one grant per cycle back-to-back (full throughput) with no bubble between owners.

Reset
REQ-028 SHALL, on reset assertion, immediately clear ram_wren, ram_address, ram_data, vga_rvalid, cpu_rvalid, vga_rdata, cpu_rdata, starve_cnt and all pipeline tags to 0/NONE.
REQ-029 SHALL, on reset mid-read, drop in-flight reads: no rvalid after reset deassertion for pre-reset grants.
REQ-030 SHALL hold vga_ack and cpu_ack low while reset is high.

Structure
REQ-031 SHALL place owner_t enum (OWN_NONE, OWN_VGA, OWN_CPU) and default width constants in shared package vram_pkg.
REQ-032 SHALL implement the tag pipeline as sub-module vram_tag_pipe (parameter DEPTH = RD_LAT).

Verification
REQ-033 SHALL test VGA-only reads: vga_req at addr 0x010 in cycle T -> vga_ack in T, ram_address = 0x010 in T+1, vga_rvalid with ram_q in T+3 (RD_LAT=2).
REQ-034 SHALL test CPU write: cpu_req/cpu_we with addr 0x020 and data 0x1FF -> cpu_ack, ram_wren = 1 and ram_data = 0x1FF next cycle, no cpu_rvalid.
REQ-035 SHALL test starvation: vga_req held continuously with cpu_req read -> cpu_ack exactly after 8 waiting cycles, then VGA regranted the following cycle.
REQ-036 SHALL test interleaving: alternating VGA/CPU reads to 0x001 and 0x002 back-to-back -> each rvalid goes to the correct owner, one per cycle, in order.
REQ-037 SHALL test reset mid-read: reset asserted 1 cycle after a VGA read ack -> all outputs 0 at once; no vga_rvalid after release.
REQ-038 SHALL assert the invariant !(vga_ack && cpu_ack) every cycle of all tests.

Source files
------------

// File: rtl/vram_pkg.sv
// Shared types and default sizes for the VRAM arbiter slice.
package vram_pkg;

  // Default geometry: 4K words of 3-bit R/G/B.
  localparam int unsigned DEF_ADDR_W     = 12;
  localparam int unsigned DEF_DATA_W     = 9;
  localparam int unsigned DEF_RD_LAT     = 2;
  localparam int unsigned DEF_STARVE_MAX = 8;

  // Which port owns the read data coming back from the RAM.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_VGA  = 2'd1,
    OWN_CPU  = 2'd2
  } owner_t;

endpackage

// File: rtl/vram_tag_pipe.sv
// Delay line carrying the read owner alongside the RAM read latency.
module vram_tag_pipe
  import vram_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_RD_LAT
) (
  input  logic   clock,
  input  logic   reset,
  input  owner_t tag_in,
  output owner_t tag_out
);

  owner_t stage_q [DEPTH];

  // Shift one tag per cycle; reset drops every in-flight read.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= OWN_NONE;
      end
    end else begin
      stage_q[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign tag_out = stage_q[DEPTH-1];

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: VGA has priority, CPU wins after STARVE_MAX waits.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned RD_LAT     = DEF_RD_LAT,
  parameter int unsigned STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_ack,
  output logic              vga_rvalid,
  output logic [DATA_W-1:0] vga_rdata,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_wren,
  output logic [DATA_W-1:0] ram_data,
  input  logic [DATA_W-1:0] ram_q
);

  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

  logic [7:0]        starve_cnt;
  logic [7:0]        starve_next;
  owner_t            issue_tag;
  owner_t            issue_tag_next;
  owner_t            ret_tag;
  logic [DATA_W-1:0] vga_rdata_hold;
  logic [DATA_W-1:0] cpu_rdata_hold;

  // Grant decision: CPU only when VGA is idle or the CPU has starved long enough.
  always_comb begin
    vga_ack        = 1'b0;
    cpu_ack        = 1'b0;
    issue_tag_next = OWN_NONE;
    if (!reset) begin
      if (cpu_req && (!vga_req || starve_cnt == STARVE_LIM)) begin
        cpu_ack = 1'b1;
      end else if (vga_req) begin
        vga_ack = 1'b1;
      end
    end
    if (vga_ack) begin
      issue_tag_next = OWN_VGA;
    end else if (cpu_ack && !cpu_we) begin
      issue_tag_next = OWN_CPU;
    end
  end

  // Starvation counter: counts denied CPU cycles, saturating at the limit.
  always_comb begin
    starve_next = starve_cnt;
    if (!cpu_req || cpu_ack) begin
      starve_next = '0;
    end else if (starve_cnt != STARVE_LIM) begin
      starve_next = starve_cnt + 8'd1;
    end
  end

  // Register the granted request onto the RAM port; idle keeps the address.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      starve_cnt  <= '0;
      issue_tag   <= OWN_NONE;
      ram_address <= '0;
      ram_wren    <= 1'b0;
      ram_data    <= '0;
    end else begin
      starve_cnt <= starve_next;
      issue_tag  <= issue_tag_next;
      ram_wren   <= 1'b0;
      if (cpu_ack) begin
        ram_address <= cpu_addr;
        ram_wren    <= cpu_we;
        ram_data    <= cpu_wdata;
      end else if (vga_ack) begin
        ram_address <= vga_addr;
      end
    end
  end

  // Tag issued with ram_address emerges exactly when ram_q holds its data.
  vram_tag_pipe #(
    .DEPTH (RD_LAT)
  ) u_tag_pipe (
    .clock   (clock),
    .reset   (reset),
    .tag_in  (issue_tag),
    .tag_out (ret_tag)
  );

  // Keep the last delivered word per port for cycles without rvalid.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vga_rdata_hold <= '0;
      cpu_rdata_hold <= '0;
    end else begin
      if (vga_rvalid) vga_rdata_hold <= ram_q;
      if (cpu_rvalid) cpu_rdata_hold <= ram_q;
    end
  end

  // Route returning data to its owner in the same cycle ram_q is valid.
  always_comb begin
    vga_rvalid = (ret_tag == OWN_VGA);
    cpu_rvalid = (ret_tag == OWN_CPU);
    vga_rdata  = vga_rvalid ? ram_q : vga_rdata_hold;
    cpu_rdata  = cpu_rvalid ? ram_q : cpu_rdata_hold;
  end

endmodule
